pool_row_collector: RTL and testbench

- Downstream end of the pooling column array.
- Accepts per-column pooling results and done strobes, which arrive skewed: column j leads column j+1 by one cycle.
- De-skews them into full aligned rows and buffers the rows in a small FIFO.
- Writes each row to the output feature-map buffer through a valid/ready write port with an auto-incrementing address. Signals completion after a programmed number of rows.

---
 rtl/pool_row_collector_if.sv | 14 +
 rtl/pool_row_collector.sv | 194 +++++++++++++++++++
 tb/tb_pool_row_collector.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pool_row_collector_if.sv
// Row write port toward the output feature-map buffer: one packed row per beat, valid/ready handshake.
interface pool_row_collector_if #(
  parameter int DATA_WIDTH = 16,
  parameter int COL        = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                      wr_valid;
  logic                      wr_ready;
  logic [ADDR_WIDTH-1:0]     wr_addr;
  logic [COL*DATA_WIDTH-1:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/pool_row_collector.sv
// De-skews per-column pooling results into rows (aligned 1 cycle after the last column's done), buffers them in a FIFO and
// writes them out; wr_ready stalls drain the FIFO, a full FIFO drops rows (overflow). ReLU option: POOL_ROW_COLLECTOR_RELU_EN.
module pool_row_collector #(
  parameter int DATA_WIDTH = 16,
  parameter int COL        = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   row_count,
  input  logic [DATA_WIDTH-1:0] pool_in   [COL],
  input  logic                  pool_done [COL],
  pool_row_collector_if.master  wr,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic                  skew_err
);
  localparam int ROW_W = COL * DATA_WIDTH;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] tap_data [COL];
  logic [COL-1:0]        tap_done;
  logic [DATA_WIDTH-1:0] al_data  [COL];
  logic [COL-1:0]        al_done;
  logic                  al_valid;
  logic                  al_mixed;
  logic [ROW_W-1:0]      row_in;

  logic [ROW_W-1:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  fifo_full, fifo_empty;

  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH:0]   rows_left;
  logic                  load, flush, push, pop, drop;

  // Column j waits COL-1-j cycles so every column of a row leaves the delay lines together.
  for (genvar j = 0; j < COL; j++) begin : g_col
    localparam int D = COL - 1 - j;
    if (D == 0) begin : g_pass
      assign tap_data[j] = pool_in[j];
      assign tap_done[j] = pool_done[j];
    end else begin : g_dly
      logic [DATA_WIDTH-1:0] sh_data [D];
      logic [D-1:0]          sh_done;
      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
          for (int k = 0; k < D; k++) sh_data[k] <= '0;
          sh_done <= '0;
        end else begin
          sh_data[0] <= pool_in[j];
          sh_done[0] <= pool_done[j];
          for (int k = 1; k < D; k++) begin
            sh_data[k] <= sh_data[k-1];
            sh_done[k] <= sh_done[k-1];
          end
        end
      end
      assign tap_data[j] = sh_data[D-1];
      assign tap_done[j] = sh_done[D-1];
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int j = 0; j < COL; j++) al_data[j] <= '0;
      al_done <= '0;
    end else begin
      for (int j = 0; j < COL; j++) al_data[j] <= tap_data[j];
      al_done <= tap_done;
    end
  end

  assign al_valid = al_done[COL-1];
  assign al_mixed = (al_done != {COL{al_valid}});

  always_comb begin
    row_in = '0;
    for (int j = 0; j < COL; j++) begin
`ifdef POOL_ROW_COLLECTOR_RELU_EN
      row_in[j*DATA_WIDTH +: DATA_WIDTH] = al_data[j][DATA_WIDTH-1] ? '0 : al_data[j];
`else
      row_in[j*DATA_WIDTH +: DATA_WIDTH] = al_data[j];
`endif
    end
  end

  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    load        = 1'b0;
    flush       = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    drop        = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    wr.wr_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = (row_count == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        busy        = 1'b1;
        wr.wr_valid = !fifo_empty;
        pop         = wr.wr_valid && wr.wr_ready;
        if (pop && rows_left == (ADDR_WIDTH+1)'(1)) begin
          state_d = DONE;
          flush   = 1'b1;
        end
        // A full FIFO still takes a row when its head leaves in the same cycle.
        if (al_valid && !flush) begin
          push = !fifo_full || pop;
          drop = fifo_full && !pop;
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= row_in;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      addr      <= '0;
      rows_left <= '0;
      overflow  <= 1'b0;
      skew_err  <= 1'b0;
    end else if (load) begin
      addr      <= base_addr;
      rows_left <= row_count;
      overflow  <= 1'b0;
      skew_err  <= 1'b0;
    end else begin
      if (pop) begin
        addr      <= addr + 1'b1;
        rows_left <= rows_left - 1'b1;
      end
      if (drop)     overflow <= 1'b1;
      if (al_mixed) skew_err <= 1'b1;
    end
  end

  assign wr.wr_addr = addr;
  assign wr.wr_data = wr.wr_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_pool_row_collector.sv
// Directed bench for pool_row_collector at COL=4, DATA_WIDTH=16, FIFO_DEPTH=4, ADDR_WIDTH=10.
module tb_pool_row_collector;
  localparam int DW  = 16;
  localparam int COL = 4;
  localparam int AW  = 10;

  logic          clk = 1'b0;
  logic          nrst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   row_count;
  logic [DW-1:0] pool_in   [COL];
  logic          pool_done [COL];
  logic          busy, done, overflow, skew_err;

  pool_row_collector_if #(.DATA_WIDTH(DW), .COL(COL), .ADDR_WIDTH(AW)) wr_if ();

  pool_row_collector #(.DATA_WIDTH(DW), .COL(COL), .FIFO_DEPTH(4), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .nrst(nrst), .start(start), .base_addr(base_addr), .row_count(row_count),
    .pool_in(pool_in), .pool_done(pool_done), .wr(wr_if),
    .busy(busy), .done(done), .overflow(overflow), .skew_err(skew_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int cyc      = 0;
  int last_acc = 0;
  int done_cyc = 0;
  logic [AW-1:0] wa_q [$];
  logic [63:0]   wd_q [$];
  bit            use_custom = 0;
  logic [DW-1:0] custom [COL];

  always @(negedge clk) begin
    cyc++;
    if (wr_if.wr_valid && wr_if.wr_ready) begin
      wa_q.push_back(wr_if.wr_addr);
      wd_q.push_back(wr_if.wr_data);
      last_acc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] row_val(input logic [DW-1:0] seed, input int r, input int j);
    if (use_custom) return custom[j];
    return seed + DW'(r * 16) + DW'(j);
  endfunction

  function automatic logic [63:0] exp_row(input logic [DW-1:0] seed, input int r);
    logic [63:0] v;
    v = '0;
    for (int j = 0; j < COL; j++) v[j*DW +: DW] = seed + DW'(r * 16) + DW'(j);
    return v;
  endfunction

  task automatic do_start(input logic [AW-1:0] ba, input logic [AW:0] rc);
    wa_q.delete();
    wd_q.delete();
    base_addr = ba;
    row_count = rc;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  // Column j fires j cycles after column 0; column 'late' fires one more cycle late.
  task automatic send_rows(input int n, input logic [DW-1:0] seed, input int r0, input int late);
    for (int j = 0; j < COL; j++) pool_in[j] = row_val(seed, r0, j);
    for (int c = 0; c < n + COL; c++) begin
      for (int j = 0; j < COL; j++) begin
        int r;
        r = c - j - ((j == late) ? 1 : 0);
        if (r >= 0 && r < n) begin
          pool_in[j]   = row_val(seed, r0 + r, j);
          pool_done[j] = 1'b1;
        end else begin
          pool_done[j] = 1'b0;
        end
      end
      step();
    end
    for (int j = 0; j < COL; j++) pool_done[j] = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n0;
    int k;
    n0 = done_cnt;
    k  = 0;
    while (done_cnt == n0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_done_seen"}, 64'(done_cnt - n0), 64'd1);
  endtask

  task automatic check_write(input string tag, input int idx, input logic [AW-1:0] ea, input logic [63:0] ed);
    if (idx < wa_q.size()) begin
      check({tag, "_addr"}, 64'(wa_q[idx]), 64'(ea));
      check({tag, "_data"}, wd_q[idx], ed);
    end else begin
      check({tag, "_present"}, 64'(wa_q.size()), 64'(idx + 1));
    end
  endtask

  initial begin
    nrst          = 1'b0;
    start         = 1'b0;
    base_addr     = '0;
    row_count     = '0;
    wr_if.wr_ready = 1'b0;
    for (int j = 0; j < COL; j++) begin
      pool_in[j]   = '0;
      pool_done[j] = 1'b0;
    end
    #3;
    check("rst_wr_valid", 64'(wr_if.wr_valid), 64'd0);
    check("rst_wr_addr",  64'(wr_if.wr_addr),  64'd0);
    check("rst_wr_data",  wr_if.wr_data,       64'd0);
    check("rst_busy",     64'(busy),           64'd0);
    check("rst_done",     64'(done),           64'd0);
    check("rst_flags",    64'({overflow, skew_err}), 64'd0);
    step();
    step();
    nrst = 1'b1;
    step();

    // Single skewed row.
    wr_if.wr_ready = 1'b1;
    do_start(10'h010, 11'd1);
    send_rows(1, 16'h0100, 0, -1);
    wait_done("single");
    check("single_count", 64'(wa_q.size()), 64'd1);
    check_write("single", 0, 10'h010, 64'h0103_0102_0101_0100);
    step();
    check("single_busy_after", 64'(busy), 64'd0);

    // Eight back-to-back rows with address wrap.
    do_start(10'h3FE, 11'd8);
    send_rows(8, 16'h0200, 0, -1);
    wait_done("b2b");
    check("b2b_count", 64'(wa_q.size()), 64'd8);
    for (int i = 0; i < 8; i++) check_write($sformatf("b2b%0d", i), i, 10'(10'h3FE + i), exp_row(16'h0200, i));
    check("b2b_done_latency", 64'(done_cyc), 64'(last_acc + 1));
    step();

    // Backpressure: four rows fill the FIFO, the fifth is dropped.
    wr_if.wr_ready = 1'b0;
    do_start(10'h100, 11'd4);
    send_rows(4, 16'h0300, 0, -1);
    step();
    step();
    check("bp_no_overflow", 64'(overflow), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_hold_valid", 64'(wr_if.wr_valid), 64'd1);
      check("bp_hold_data",  wr_if.wr_data, exp_row(16'h0300, 0));
      check("bp_hold_addr",  64'(wr_if.wr_addr), 64'h100);
      step();
    end
    do_start(10'h200, 11'd0);
    @(negedge clk);
    check("bp_start_ignored_busy", 64'(busy), 64'd1);
    check("bp_start_ignored_addr", 64'(wr_if.wr_addr), 64'h100);
    step();
    send_rows(1, 16'h0300, 4, -1);
    step();
    step();
    check("bp_overflow", 64'(overflow), 64'd1);
    check("bp_no_writes_yet", 64'(wa_q.size()), 64'd0);
    wr_if.wr_ready = 1'b1;
    wait_done("bp");
    check("bp_count", 64'(wa_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) check_write($sformatf("bp%0d", i), i, 10'(10'h100 + i), exp_row(16'h0300, i));
    check("bp_overflow_sticky", 64'(overflow), 64'd1);
    step();

    // Column 2 one cycle late.
    do_start(10'h020, 11'd1);
    check("skew_overflow_cleared", 64'(overflow), 64'd0);
    send_rows(1, 16'h0500, 0, 2);
    wait_done("skew");
    check("skew_err", 64'(skew_err), 64'd1);
    check("skew_count", 64'(wa_q.size()), 64'd1);
    check_write("skew", 0, 10'h020, exp_row(16'h0500, 0));
    step();

    // Zero-row transfer.
    do_start(10'h030, 11'd0);
    @(negedge clk);
    check("zero_done", 64'(done), 64'd1);
    check("zero_busy", 64'(busy), 64'd1);
    check("zero_skew_cleared", 64'(skew_err), 64'd0);
    step();
    @(negedge clk);
    check("zero_done_once", 64'(done), 64'd0);
    check("zero_idle", 64'(busy), 64'd0);
    check("zero_writes", 64'(wa_q.size()), 64'd0);
    step();

    // Negative elements with and without ReLU.
    use_custom = 1;
    custom[0] = 16'hFF38;
    custom[1] = 16'h00C8;
    custom[2] = 16'h8000;
    custom[3] = 16'h7FFF;
    do_start(10'h040, 11'd1);
    send_rows(1, 16'h0000, 0, -1);
    wait_done("relu");
`ifdef POOL_ROW_COLLECTOR_RELU_EN
    check_write("relu", 0, 10'h040, 64'h7FFF_0000_00C8_0000);
`else
    check_write("relu", 0, 10'h040, 64'h7FFF_8000_00C8_FF38);
`endif
    use_custom = 0;
    step();

    // Reset in the middle of a stalled, overflowed transfer.
    wr_if.wr_ready = 1'b0;
    do_start(10'h080, 11'd4);
    send_rows(5, 16'h0600, 0, -1);
    step();
    step();
    check("mid_overflow", 64'(overflow), 64'd1);
    check("mid_valid", 64'(wr_if.wr_valid), 64'd1);
    #2;
    nrst = 1'b0;
    #1;
    check("mid_rst_wr_valid", 64'(wr_if.wr_valid), 64'd0);
    check("mid_rst_wr_addr",  64'(wr_if.wr_addr),  64'd0);
    check("mid_rst_wr_data",  wr_if.wr_data,       64'd0);
    check("mid_rst_busy",     64'(busy),           64'd0);
    check("mid_rst_done",     64'(done),           64'd0);
    check("mid_rst_flags",    64'({overflow, skew_err}), 64'd0);
    step();
    nrst = 1'b1;
    step();
    @(negedge clk);
    check("post_rst_idle", 64'({busy, wr_if.wr_valid}), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running, expected finished");
    $fatal(1);
  end
endmodule
